// File: rtl/decode_ctrl_pipe.sv
// RV32I(+M) decode-stage control unit: decodes InstrD into the control bundle,
// registers it into the D/E stage and tracks mul/div occupancy for back-pressure.
module decode_ctrl_pipe #(
  parameter bit ENABLE_M   = 1'b1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] InstrD,
  input  logic        ValidD,
  input  logic        StallE,
  input  logic        FlushE,
  output logic        StallD,
  output logic        ValidE,
  output logic        IllegalE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        JumpTypeE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic        MulDivE,
  output logic [2:0]  ResultSrcE,
  output logic [2:0]  BranchTypeE,
  output logic [2:0]  ALUControlE,
  output logic [2:0]  ImmSrcE,
  output logic [2:0]  StrobeE,
  output logic [2:0]  MulDivOpE,
  output logic [1:0]  SLTControlE,
  output logic        MdReadyE
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_IMM = 7'b0010011, OP_AUIPC = 7'b0010111,
                         OP_STORE = 7'b0100011, OP_REG = 7'b0110011, OP_LUI = 7'b0110111,
                         OP_BRANCH = 7'b1100011, OP_JALR = 7'b1100111, OP_JAL = 7'b1101111;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic       valid, illegal, reg_write, mem_write, jump, jump_type, branch, alu_src, mul_div;
    logic [2:0] result_src, branch_type, alu_control, imm_src, strobe, mul_div_op;
    logic [1:0] slt_control;
  } ctrl_t;

  typedef enum logic {IDLE, BUSY} state_e;

  ctrl_t               dec, ctrl_d, ctrl_q;
  logic [CNT_W-1:0]    count_d, count_q;
  state_e              state;
  logic                illegal;
  logic [6:0]          opcode, funct7;
  logic [2:0]          funct3;
  logic                unused_instr_bits;

  // {ALUControl, SLTControl} for OP/OP-IMM; alt selects SUB on 000 and SRA on 101.
  function automatic logic [4:0] alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_sel = alt ? 5'b001_00 : 5'b000_00;
      3'b001:  alu_sel = 5'b101_00;
      3'b010:  alu_sel = 5'b001_01;
      3'b011:  alu_sel = 5'b001_10;
      3'b100:  alu_sel = 5'b100_00;
      3'b101:  alu_sel = alt ? 5'b110_00 : 5'b111_00;
      3'b110:  alu_sel = 5'b011_00;
      default: alu_sel = 5'b010_00;
    endcase
  endfunction

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];
  assign unused_instr_bits = ^{InstrD[24:15], InstrD[11:7]};

  // D stage: combinational decode
  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    case (opcode)
      OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        {dec.alu_control, dec.slt_control} = alu_sel(funct3, (funct3 == 3'b101) && InstrD[30]);
        if (funct3 == 3'b001 || funct3 == 3'b101) dec.imm_src = 3'b101;
        if (funct3 == 3'b001 && funct7 != F7_BASE) illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT) illegal = 1'b1;
      end
      OP_REG: begin
        if (funct7 == F7_MULDIV) begin
          if (ENABLE_M) begin
            dec.mul_div    = 1'b1;
            dec.mul_div_op = funct3;
            dec.reg_write  = 1'b1;
            dec.result_src = 3'b101;
          end else begin
            illegal = 1'b1;
          end
        end else begin
          dec.reg_write = 1'b1;
          {dec.alu_control, dec.slt_control} = alu_sel(funct3, funct7 == F7_ALT);
          if (!(funct7 == F7_BASE ||
                (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))) illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 3'b001;
        dec.alu_src    = 1'b1;
        dec.strobe     = funct3;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 3'b001;
        dec.strobe    = funct3;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 3'b010;
        dec.imm_src    = 3'b011;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.jump_type  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 3'b010;
      end
      OP_BRANCH: begin
        dec.branch      = 1'b1;
        dec.alu_control = 3'b001;
        dec.imm_src     = 3'b010;
        dec.branch_type = funct3;
        if (funct3[2]) dec.slt_control = funct3[1] ? 2'b10 : 2'b01;
        if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 3'b011;
        dec.imm_src    = 3'b100;
      end
      OP_AUIPC: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 3'b100;
        dec.imm_src    = 3'b100;
      end
      default: illegal = 1'b1;
    endcase
    if (!ValidD) begin
      dec = '0;
    end else if (illegal) begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.illegal = 1'b1;
    end else begin
      dec.valid = 1'b1;
    end
  end

  assign state = (count_q != '0) ? BUSY : IDLE;

  // D/E boundary: flush beats stall; BUSY counts down even while StallE holds E
  always_comb begin
    ctrl_d  = ctrl_q;
    count_d = count_q;
    if (FlushE) begin
      ctrl_d  = '0;
      count_d = '0;
    end else if (StallE || state == BUSY) begin
      if (state == BUSY) count_d = count_q - 1'b1;
    end else begin
      ctrl_d  = dec;
      count_d = dec.mul_div ? (dec.mul_div_op[2] ? DIV_LAST : MUL_LAST) : '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctrl_q  <= '0;
      count_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
    end
  end

  assign StallD      = StallE | (state == BUSY);
  assign MdReadyE    = ctrl_q.valid & ctrl_q.mul_div & (state == IDLE);
  assign ValidE      = ctrl_q.valid;
  assign IllegalE    = ctrl_q.illegal;
  assign RegWriteE   = ctrl_q.reg_write;
  assign MemWriteE   = ctrl_q.mem_write;
  assign JumpE       = ctrl_q.jump;
  assign JumpTypeE   = ctrl_q.jump_type;
  assign BranchE     = ctrl_q.branch;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign MulDivE     = ctrl_q.mul_div;
  assign ResultSrcE  = ctrl_q.result_src;
  assign BranchTypeE = ctrl_q.branch_type;
  assign ALUControlE = ctrl_q.alu_control;
  assign ImmSrcE     = ctrl_q.imm_src;
  assign StrobeE     = ctrl_q.strobe;
  assign MulDivOpE   = ctrl_q.mul_div_op;
  assign SLTControlE = ctrl_q.slt_control;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: fixed vector table, multi-cycle mul/div/flush/reset
// sequences and randomized traffic against a behavioural model of the E stage.
module tb_decode_ctrl_pipe;

  localparam int MUL_A = 2;
  localparam int DIV_A = 33;

  logic        CLK = 1'b0;
  logic        RST, ValidD, StallE, FlushE;
  logic [31:0] InstrD;

  logic a_StallD, a_ValidE, a_IllegalE, a_RegWriteE, a_MemWriteE, a_JumpE, a_JumpTypeE;
  logic a_BranchE, a_ALUSrcE, a_MulDivE, a_MdReadyE;
  logic [2:0] a_ResultSrcE, a_BranchTypeE, a_ALUControlE, a_ImmSrcE, a_StrobeE, a_MulDivOpE;
  logic [1:0] a_SLTControlE;
  logic b_StallD, b_ValidE, b_IllegalE, b_RegWriteE, b_MemWriteE, b_JumpE, b_JumpTypeE;
  logic b_BranchE, b_ALUSrcE, b_MulDivE, b_MdReadyE;
  logic [2:0] b_ResultSrcE, b_BranchTypeE, b_ALUControlE, b_ImmSrcE, b_StrobeE, b_MulDivOpE;
  logic [1:0] b_SLTControlE;

  decode_ctrl_pipe #(.ENABLE_M(1'b1), .MUL_CYCLES(MUL_A), .DIV_CYCLES(DIV_A)) dut_a (
    .CLK(CLK), .RST(RST), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
    .StallD(a_StallD), .ValidE(a_ValidE), .IllegalE(a_IllegalE), .RegWriteE(a_RegWriteE),
    .MemWriteE(a_MemWriteE), .JumpE(a_JumpE), .JumpTypeE(a_JumpTypeE), .BranchE(a_BranchE),
    .ALUSrcE(a_ALUSrcE), .MulDivE(a_MulDivE), .ResultSrcE(a_ResultSrcE),
    .BranchTypeE(a_BranchTypeE), .ALUControlE(a_ALUControlE), .ImmSrcE(a_ImmSrcE),
    .StrobeE(a_StrobeE), .MulDivOpE(a_MulDivOpE), .SLTControlE(a_SLTControlE),
    .MdReadyE(a_MdReadyE));

  decode_ctrl_pipe #(.ENABLE_M(1'b0), .MUL_CYCLES(2), .DIV_CYCLES(33)) dut_b (
    .CLK(CLK), .RST(RST), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
    .StallD(b_StallD), .ValidE(b_ValidE), .IllegalE(b_IllegalE), .RegWriteE(b_RegWriteE),
    .MemWriteE(b_MemWriteE), .JumpE(b_JumpE), .JumpTypeE(b_JumpTypeE), .BranchE(b_BranchE),
    .ALUSrcE(b_ALUSrcE), .MulDivE(b_MulDivE), .ResultSrcE(b_ResultSrcE),
    .BranchTypeE(b_BranchTypeE), .ALUControlE(b_ALUControlE), .ImmSrcE(b_ImmSrcE),
    .StrobeE(b_StrobeE), .MulDivOpE(b_MulDivOpE), .SLTControlE(b_SLTControlE),
    .MdReadyE(b_MdReadyE));

  always #5 CLK = ~CLK;

  // Bundle layout: v ill rw mw j jt br as md | rs bt alu imm strb mdop | slt
  logic [28:0] obs_a, obs_b;
  assign obs_a = {a_ValidE, a_IllegalE, a_RegWriteE, a_MemWriteE, a_JumpE, a_JumpTypeE,
                  a_BranchE, a_ALUSrcE, a_MulDivE, a_ResultSrcE, a_BranchTypeE,
                  a_ALUControlE, a_ImmSrcE, a_StrobeE, a_MulDivOpE, a_SLTControlE};
  assign obs_b = {b_ValidE, b_IllegalE, b_RegWriteE, b_MemWriteE, b_JumpE, b_JumpTypeE,
                  b_BranchE, b_ALUSrcE, b_MulDivE, b_ResultSrcE, b_BranchTypeE,
                  b_ALUControlE, b_ImmSrcE, b_StrobeE, b_MulDivOpE, b_SLTControlE};

  int          total = 0;
  int          bad   = 0;
  logic [28:0] exp_a = '0, exp_b = '0;
  int          busy_a = 0;

  function automatic logic [28:0] pk(input bit v, ill, rw, mw, j, jt, br, as, md,
                                     input int rs, bt, alu, imm, strb, mdop, slt);
    return {v, ill, rw, mw, j, jt, br, as, md, 3'(rs), 3'(bt), 3'(alu), 3'(imm),
            3'(strb), 3'(mdop), 2'(slt)};
  endfunction

  function automatic logic [4:0] alu_of(input logic [2:0] f3, input bit alt);
    logic [2:0] names [8];
    logic [1:0] slt;
    names = '{3'd0, 3'd5, 3'd1, 3'd1, 3'd4, 3'd7, 3'd3, 3'd2};
    slt = (f3 == 3'd2) ? 2'd1 : (f3 == 3'd3) ? 2'd2 : 2'd0;
    if (alt && f3 == 3'd0) return {3'd1, slt};
    if (alt && f3 == 3'd5) return {3'd6, slt};
    return {names[f3], slt};
  endfunction

  // Reference decode straight from the instruction-class rules.
  function automatic logic [28:0] ref_dec(input logic [31:0] ins, input logic vd, input bit en_m);
    logic [6:0] op, f7;
    logic [2:0] f3, rs, bt, alu, imm, strb, mdop;
    logic [1:0] slt;
    bit rw, mw, j, jt, br, as, md, ill;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    {rw, mw, j, jt, br, as, md, ill} = '0;
    {rs, bt, alu, imm, strb, mdop, slt} = '0;
    if (!vd) return '0;
    case (op)
      7'h13: begin
        rw = 1; as = 1; {alu, slt} = alu_of(f3, f3 == 3'd5 && f7 == 7'h20);
        if (f3 == 3'd1 || f3 == 3'd5) imm = 3'd5;
        if (f3 == 3'd1 && f7 != 7'h00) ill = 1;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ill = 1;
      end
      7'h33: begin
        if (f7 == 7'h01) begin
          if (en_m) begin md = 1; mdop = f3; rw = 1; rs = 3'd5; end
          else ill = 1;
        end else begin
          rw = 1; {alu, slt} = alu_of(f3, f7 == 7'h20);
          if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) ill = 1;
        end
      end
      7'h03: begin rw = 1; rs = 3'd1; as = 1; strb = f3; end
      7'h23: begin mw = 1; as = 1; imm = 3'd1; strb = f3; end
      7'h6F: begin rw = 1; j = 1; rs = 3'd2; imm = 3'd3; end
      7'h67: begin rw = 1; j = 1; jt = 1; as = 1; rs = 3'd2; end
      7'h63: begin
        br = 1; alu = 3'd1; imm = 3'd2; bt = f3;
        if (f3 == 3'd2 || f3 == 3'd3) ill = 1;
        else if (f3[2]) slt = f3[1] ? 2'd2 : 2'd1;
      end
      7'h37: begin rw = 1; rs = 3'd3; imm = 3'd4; end
      7'h17: begin rw = 1; rs = 3'd4; imm = 3'd4; end
      default: ill = 1;
    endcase
    if (ill) return {2'b11, 27'd0};
    return {1'b1, 1'b0, rw, mw, j, jt, br, as, md, rs, bt, alu, imm, strb, mdop, slt};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Check combinational outputs, clock once, advance the model, check E outputs.
  task automatic step();
    #1;
    chk("stalld_a", 32'(a_StallD), 32'(StallE | (busy_a > 0)));
    chk("mdready_a", 32'(a_MdReadyE), 32'(exp_a[28] & exp_a[20] & (busy_a == 0)));
    chk("stalld_b", 32'(b_StallD), 32'(StallE));
    @(posedge CLK);
    if (FlushE) begin
      exp_a = '0; busy_a = 0;
    end else if (StallE || busy_a > 0) begin
      if (busy_a > 0) busy_a--;
    end else begin
      exp_a = ref_dec(InstrD, ValidD, 1'b1);
      busy_a = exp_a[20] ? ((exp_a[4] ? DIV_A : MUL_A) - 1) : 0;
    end
    if (FlushE) exp_b = '0;
    else if (!StallE) exp_b = ref_dec(InstrD, ValidD, 1'b0);
    #1;
    chk("e_a", 32'(obs_a), 32'(exp_a));
    chk("e_b", 32'(obs_b), 32'(exp_b));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9];
    logic [31:0] ins;
    ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
    ins = $urandom;
    if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 8)];
    case ($urandom_range(0, 3))
      0: ins[31:25] = 7'h00;
      1: ins[31:25] = 7'h20;
      2: ins[31:25] = 7'h01;
      default: ;
    endcase
    return ins;
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic        vd;
    bit          on_b;
    logic [28:0] req;
  } vec_t;

  localparam logic [31:0] I_ADDI = 32'h00500093, I_ADD = 32'h002081B3, I_SUB = 32'h402081B3;
  localparam logic [31:0] I_DIV = 32'h0220C1B3, I_MUL = 32'h022081B3;

  vec_t tbl [17];
  int   cnt;

  initial begin
    tbl[0]  = '{I_ADDI,        1'b1, 1'b0, pk(1,0,1,0,0,0,0,1,0, 0,0,0,0,0,0,0)};
    tbl[1]  = '{32'h4010D093,  1'b1, 1'b0, pk(1,0,1,0,0,0,0,1,0, 0,0,6,5,0,0,0)};
    tbl[2]  = '{32'h4210D093,  1'b1, 1'b0, pk(1,1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0)};
    tbl[3]  = '{32'h0000007F,  1'b1, 1'b0, pk(1,1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0)};
    tbl[4]  = '{I_SUB,         1'b1, 1'b0, pk(1,0,1,0,0,0,0,0,0, 0,0,1,0,0,0,0)};
    tbl[5]  = '{32'h0020B1B3,  1'b1, 1'b0, pk(1,0,1,0,0,0,0,0,0, 0,0,1,0,0,0,2)};
    tbl[6]  = '{32'h00412083,  1'b1, 1'b0, pk(1,0,1,0,0,0,0,1,0, 1,0,0,0,2,0,0)};
    tbl[7]  = '{32'h00112223,  1'b1, 1'b0, pk(1,0,0,1,0,0,0,1,0, 0,0,0,1,2,0,0)};
    tbl[8]  = '{32'h0020C463,  1'b1, 1'b0, pk(1,0,0,0,0,0,1,0,0, 0,4,1,2,0,0,1)};
    tbl[9]  = '{32'h0020F463,  1'b1, 1'b0, pk(1,0,0,0,0,0,1,0,0, 0,7,1,2,0,0,2)};
    tbl[10] = '{32'h0020A463,  1'b1, 1'b0, pk(1,1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0)};
    tbl[11] = '{32'h008000EF,  1'b1, 1'b0, pk(1,0,1,0,1,0,0,0,0, 2,0,0,3,0,0,0)};
    tbl[12] = '{32'h000100E7,  1'b1, 1'b0, pk(1,0,1,0,1,1,0,1,0, 2,0,0,0,0,0,0)};
    tbl[13] = '{32'h123450B7,  1'b1, 1'b0, pk(1,0,1,0,0,0,0,0,0, 3,0,0,4,0,0,0)};
    tbl[14] = '{32'h12345097,  1'b1, 1'b0, pk(1,0,1,0,0,0,0,0,0, 4,0,0,4,0,0,0)};
    tbl[15] = '{I_ADDI,        1'b0, 1'b0, pk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0)};
    tbl[16] = '{I_DIV,         1'b1, 1'b1, pk(1,1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0)};

    RST = 1'b1; ValidD = 1'b0; StallE = 1'b0; FlushE = 1'b0; InstrD = '0;
    #12;
    chk("reset_e_a", 32'(obs_a), 0);
    chk("reset_stalld", 32'(a_StallD), 0);
    chk("reset_mdready", 32'(a_MdReadyE), 0);
    RST = 1'b0;

    for (int i = 0; i < 17; i++) begin
      InstrD = tbl[i].ins; ValidD = tbl[i].vd;
      step();
      chk($sformatf("tbl%0d", i), 32'(tbl[i].on_b ? obs_b : obs_a), 32'(tbl[i].req));
    end
    ValidD = 1'b0;
    for (int k = 0; k < 40 && busy_a > 0; k++) step();

    // DIV: StallD high for DIV_CYCLES-1 cycles, result ready on the next
    InstrD = I_DIV; ValidD = 1'b1;
    step();
    chk("div_op", 32'(a_MulDivOpE), 4);
    chk("div_rs", 32'(a_ResultSrcE), 5);
    InstrD = I_ADDI; cnt = 0;
    for (int k = 0; k < 40 && a_StallD; k++) begin cnt++; step(); end
    chk("div_stall_cycles", cnt, DIV_A - 1);
    chk("div_ready", 32'(a_MdReadyE), 1);
    step();

    InstrD = I_MUL;
    step();
    InstrD = I_ADDI; cnt = 0;
    for (int k = 0; k < 40 && a_StallD; k++) begin cnt++; step(); end
    chk("mul_stall_cycles", cnt, MUL_A - 1);
    chk("mul_ready", 32'(a_MdReadyE), 1);

    // Stall with a completed MUL in E keeps MdReadyE asserted
    StallE = 1'b1;
    step();
    chk("mul_ready_held", 32'(a_MdReadyE), 1);
    StallE = 1'b0;
    step();

    // Flush during BUSY aborts the divide
    InstrD = I_DIV;
    step();
    InstrD = I_ADDI;
    for (int k = 0; k < 40 && busy_a > 20; k++) step();
    chk("flush_at_count20", busy_a, 20);
    FlushE = 1'b1;
    step();
    chk("flush_valid", 32'(a_ValidE), 0);
    FlushE = 1'b0;
    #1;
    chk("flush_stalld", 32'(a_StallD), 0);

    // Asynchronous reset during BUSY clears everything before the next edge
    InstrD = I_DIV;
    step();
    InstrD = I_ADDI;
    repeat (5) step();
    RST = 1'b1;
    #1;
    chk("rst_e_a", 32'(obs_a), 0);
    chk("rst_e_b", 32'(obs_b), 0);
    chk("rst_stalld", 32'(a_StallD), 0);
    chk("rst_mdready", 32'(a_MdReadyE), 0);
    exp_a = '0; exp_b = '0; busy_a = 0;
    #2;
    RST = 1'b0;

    // StallE holds ADD for 3 cycles; flush overrides stall
    InstrD = I_ADD;
    step();
    StallE = 1'b1; InstrD = I_SUB;
    repeat (3) begin
      step();
      chk("hold_add", 32'(obs_a), 32'(pk(1,0,1,0,0,0,0,0,0, 0,0,0,0,0,0,0)));
    end
    FlushE = 1'b1;
    step();
    chk("flush_over_stall", 32'(obs_a), 0);
    FlushE = 1'b0; StallE = 1'b0;

    for (int n = 0; n < 400; n++) begin
      InstrD = rand_instr();
      ValidD = ($urandom_range(0, 3) != 0);
      StallE = ($urandom_range(0, 7) == 0);
      FlushE = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Registered decode-stage control unit for the RV32I pipeline, extended with optional M-extension issue control. It decodes the D-stage instruction into the standard control bundle and captures it into the D/E pipeline register with stall, flush and valid handling. For MUL/DIV instructions it tracks the multi-cycle occupancy of the mul/div unit and back-pressures the front end until the result is ready. It sits between the IF/ID register and the execute stage; its E-side outputs drive the ALU, branch unit and hazard unit directly.

## Interface
- ENABLE_M, 1, when 1 decodes funct7=0000001 R-type as M-extension; when 0 those encodings are illegal
- MUL_CYCLES, 2, E-stage occupancy of MUL/MULH/MULHSU/MULHU in cycles, ≥1
- DIV_CYCLES, 33, E-stage occupancy of DIV/DIVU/REM/REMU in cycles, ≥1
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-high
- InstrD  in  32  D-stage instruction
- ValidD  in  1  InstrD holds a real instruction
- StallE  in  1  hold E register (downstream hazard)
- FlushE  in  1  bubble E register (branch/jump taken)
- StallD  out  1  combinational: StallE | busy; front end must hold InstrD
- ValidE, IllegalE, RegWriteE, MemWriteE, JumpE, JumpTypeE, BranchE, ALUSrcE, MulDivE  out  1 each  registered control bits
- ResultSrcE, BranchTypeE, ALUControlE, ImmSrcE, StrobeE, MulDivOpE  out  3 each  registered control fields
- SLTControlE  out  2  registered compare mode
- MdReadyE  out  1  combinational: ValidE & MulDivE & count==0

## Operation
- Encodings: ResultSrc 000 ALU, 001 load, 010 PC+4, 011 imm, 100 PC+imm, 101 mul/div; ImmSrc 000 I, 001 S, 010 B, 011 J, 100 U, 101 shamt; ALUControl ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLL 101, SRA 110, SRL 111; SLTControl 00 none, 01 signed, 10 unsigned.
- OP-IMM/OP: funct3 000 ADD (SUB if OP & funct7=0100000), 001 SLL, 010 SUB+SLT 01, 011 SUB+SLT 10, 100 XOR, 101 SRL/SRA by funct7[5], 110 OR, 111 AND; ALUSrc=1 for OP-IMM; ImmSrc=101 for shifts.
- LOAD: ResultSrc 001, ALUSrc 1, ADD, Strobe=funct3. STORE: MemWrite 1, RegWrite 0, ImmSrc 001, Strobe=funct3.
- JAL: Jump 1, ResultSrc 010, ImmSrc 011. JALR: also JumpType 1, ImmSrc 000. BRANCH: Branch 1, SUB, ImmSrc 010, BranchType=funct3, SLT 01 for 10x, 10 for 11x. LUI: ResultSrc 011; AUIPC: ResultSrc 100; both ImmSrc 100.
- M-ext (OP, funct7=0000001, ENABLE_M=1): MulDiv 1, MulDivOp=funct3, RegWrite 1, ResultSrc 101; latency MUL_CYCLES if funct3[2]=0 else DIV_CYCLES.
- Illegal: unknown opcode; funct7 not 0000000 except 0100000 on OP 000/101 and on OP-IMM 101; OP-IMM 001 with funct7≠0; unused branch funct3 010/011. Result: IllegalE=1, ValidE=1, RegWrite/MemWrite/Jump/Branch/MulDiv = 0, other fields 0.
- Unused fields for a given instruction are 0. ValidD=0 captures an all-zero bubble.
- Busy counter `count` (width clog2(DIV_CYCLES+1)); states IDLE (count==0) and BUSY (count≠0). Capture of a valid mul/div loads count = latency−1; BUSY decrements every cycle regardless of StallE; reaching 0 returns to IDLE.

## Timing
- Reset (async, immediate): all registered outputs 0, count 0; StallD and MdReadyE therefore 0.
- E register update priority each edge: FlushE → bubble (all 0) and count←0; else StallE or BUSY → hold; else capture decode of InstrD.
- Decode-to-E latency 1 cycle; StallD asserts in the cycle after mul/div capture when latency>1 and stays high latency−1 cycles.
- Latency 1: no BUSY, MdReadyE high in capture cycle+0 (same cycle E is valid).
- FlushE with StallE: flush wins. FlushE during BUSY: abort, StallD low next cycle.
- MdReadyE stays high while StallE holds a completed mul/div in E.

## Test plan
- ADDI x1,x0,5 (0x00500093), ValidD=1 -> next cycle ValidE=1, RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmSrcE=000, IllegalE=0.
- SRAI x1,x1,1 (0x4010D093) -> ALUControlE=110, ImmSrcE=101; same with funct7=0100001 -> IllegalE=1, RegWriteE=0.
- DIV x3,x1,x2 (0x0220C1B3), DIV_CYCLES=33 -> MulDivOpE=100, ResultSrcE=101, StallD high exactly 32 cycles, MdReadyE high on cycle 33; MUL (funct3 000) -> StallD 1 cycle.
- Opcode 0x0000007F -> IllegalE=1, all write/jump/branch bits 0; ENABLE_M=0 with DIV encoding -> IllegalE=1.
- DIV in BUSY at count=20, assert FlushE -> E bubbles, StallD 0 next cycle; repeat asserting RST instead -> all outputs 0 immediately, before next edge.
- StallE held 3 cycles with ADD in E and new InstrD -> E outputs unchanged; FlushE+StallE same cycle -> bubble.
